// File: rtl/hc138_pkg.sv
// Shared definitions for the HC138-style strobe decoder: FSM encoding and
// default strobe/gap widths.
package hc138_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned PULSE_LEN_DEF = 4;
  localparam int unsigned GAP_LEN_DEF   = 1;

endpackage

// File: rtl/hc138_strobe_decoder_dec3to8.sv
// 3-to-8 decoder: active-low code in, active-low one-hot out, all-high when
// disabled.
module dec3to8 (
  input  logic [2:0] i_code_n,
  input  logic       i_en,
  output logic [7:0] o_y_n
);

  logic [2:0] w_idx;

  assign w_idx = ~i_code_n;

  always_comb begin
    o_y_n = 8'hFF;
    if (i_en) o_y_n[w_idx] = 1'b0;
  end

endmodule

// File: rtl/hc138_strobe_decoder.sv
// Strobe decoder: turns encoder requests into fixed-width one-hot active-low
// strobes with a guaranteed all-high gap, a one-deep pending slot and a sticky
// overrun flag.
//
//   state | meaning
//   IDLE  | no strobe, Y_n all high, waiting for an event
//   PULSE | one Y_n bit low, counting PULSE_LEN cycles
//   GAP   | Y_n all high, counting GAP_LEN cycles before the next strobe
module hc138_strobe_decoder
  import hc138_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
  parameter int unsigned GAP_LEN   = GAP_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] CodeIn,
  input  logic       GS_n,
  input  logic       G1,
  input  logic       G2A_n,
  input  logic       G2B_n,
  input  logic       ClrOvr,
  output logic [7:0] Y_n,
  output logic       Busy,
  output logic       Overrun
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_y_n, w_y_n_nxt;
  logic       r_gs_prev;
  logic       r_pend_v, w_pend_v_nxt;
  logic [2:0] r_pend, w_pend_nxt;
  logic       r_ovr;
  logic       w_ovr_set;
  logic       w_event;
  logic       w_decide;
  logic       w_start;
  logic       w_ev_used;
  logic       w_consumed;
  logic [2:0] w_start_code;
  logic [7:0] w_dec_y_n;

  assign w_event = ~GS_n & r_gs_prev & G1 & ~G2A_n & ~G2B_n;

  dec3to8 u_dec (
    .i_code_n (w_start_code),
    .i_en     (w_start),
    .o_y_n    (w_dec_y_n)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_y_n_nxt    = r_y_n;
    w_pend_v_nxt = r_pend_v;
    w_pend_nxt   = r_pend;
    w_ovr_set    = 1'b0;
    w_decide     = 1'b0;
    w_start      = 1'b0;
    w_ev_used    = 1'b0;
    w_consumed   = 1'b0;
    w_start_code = CodeIn;

    case (r_state)
      IDLE: begin
        w_y_n_nxt = 8'hFF;
        if (w_event) begin
          w_start   = 1'b1;
          w_ev_used = 1'b1;
        end
      end
      PULSE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_y_n_nxt = 8'hFF;
          if (GAP_LEN != 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = 8'(GAP_LEN - 1);
          end else begin
            w_decide = 1'b1;
          end
        end
      end
      GAP: begin
        if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
        else               w_decide  = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_y_n_nxt   = 8'hFF;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // Pending request always wins over a fresh event at a decision edge.
    if (w_decide) begin
      if (r_pend_v) begin
        w_start      = 1'b1;
        w_start_code = r_pend;
        w_consumed   = 1'b1;
        w_pend_v_nxt = 1'b0;
      end else if (w_event) begin
        w_start   = 1'b1;
        w_ev_used = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    end

    if (w_start) begin
      w_state_nxt = PULSE;
      w_cnt_nxt   = 8'(PULSE_LEN - 1);
      w_y_n_nxt   = w_dec_y_n;
    end

    if (w_event && !w_ev_used) begin
      if (!r_pend_v || w_consumed) begin
        w_pend_v_nxt = 1'b1;
        w_pend_nxt   = CodeIn;
      end else begin
        w_ovr_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_y_n     <= 8'hFF;
      r_gs_prev <= 1'b1;
      r_pend_v  <= 1'b0;
      r_pend    <= 3'b111;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_y_n     <= w_y_n_nxt;
      r_gs_prev <= GS_n;
      r_pend_v  <= w_pend_v_nxt;
      r_pend    <= w_pend_nxt;
      r_ovr     <= (r_ovr & ~ClrOvr) | w_ovr_set;
    end
  end

  assign Y_n     = r_y_n;
  assign Busy    = (r_state != IDLE);
  assign Overrun = r_ovr;

endmodule
